sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/cpu_pkg.sv | 15 +
 rtl/arb_prio.sv | 38 +++
 rtl/sram_arbiter.sv | 80 ++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: SRAM port owner encoding and default bus widths.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 3;

    // Requester that owns the response slot of the SRAM pipeline.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_prio.sv
// Two-input priority arbiter: data normally wins; inst is forced through after
// STARVE_MAX consecutive data grants taken while it was waiting.
module arb_prio #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Grants are combinational so the SRAM is enabled in the request cycle.
    always_comb begin
        starved    = (starve_cnt == CNT_MAX);
        grant_inst = !reset && inst_req && (!data_req || starved);
        grant_data = !reset && data_req && !grant_inst;
    end

    // Counts data wins over a waiting fetch; any inst win or idle inst resets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst_req || grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store
// ports, one access per cycle, with the response routed one cycle later.
module sram_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  sram_en,
    output logic [DATA_W/8-1:0]   sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    logic   grant_inst;
    logic   grant_data;
    owner_e owner;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_prio (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // Grant-cycle SRAM command mux.
    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst || grant_data;
        sram_we      = (grant_data && data_wr) ? data_wstrb : '0;
        sram_addr    = grant_data ? data_addr : inst_addr;
        sram_wdata   = data_wdata;
    end

    // Remembers who was granted so the next cycle's read data is routed back.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else if (grant_data) begin
            owner <= OWN_DATA;
        end else if (grant_inst) begin
            owner <= OWN_INST;
        end else begin
            owner <= OWN_NONE;
        end
    end

    always_comb begin
        inst_data_ok = !reset && (owner == OWN_INST);
        data_data_ok = !reset && (owner == OWN_DATA);
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: grants, starvation rotation, store strobes,
// response routing and reset behaviour against a small behavioural SRAM.
module tb_sram_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          sram_en;
    logic [SW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Single-port SRAM with one-cycle read latency and byte write enables.
    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_en) begin
            w = mem.exists(sram_addr) ? mem[sram_addr] : 32'hDEAD_BEEF;
            if (sram_we == '0) begin
                sram_rdata <= w;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[sram_addr] = w;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [3:0] ws,
                         input logic [31:0] da, input logic [31:0] wd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ws;
        data_addr  = da;
        data_wdata = wd;
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic gi, input logic gd);
        chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'(gi));
        chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'(gd));
        chk({tag, "_sram_en"},      32'(sram_en),      32'(gi | gd));
    endtask

    task automatic chk_resp(input string tag, input logic oi, input logic od);
        chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(oi));
        chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(od));
    endtask

    initial begin
        logic [7:0] pat;
        logic [6:0] ir_pat;
        logic [6:0] gd_pat;

        mem[32'h1C00_0000] = 32'h0280_0400;
        mem[32'h1C00_0004] = 32'h3333_4444;
        mem[32'h0000_2000] = 32'h1111_2222;
        mem[32'h0000_1000] = 32'h1122_3344;

        // Requests present during reset must not be granted.
        reset = 1'b1;
        drive(1, 32'h1C00_0000, 1, 1, 4'hF, 32'h2000, 32'h0);
        next_cycle();
        chk_grant("rst0", 0, 0);
        chk("rst0_sram_we", 32'(sram_we), 32'h0);
        chk_resp("rst0", 0, 0);
        next_cycle();
        chk_grant("rst1", 0, 0);
        chk_resp("rst1", 0, 0);

        reset = 1'b0;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        chk_grant("idle", 0, 0);
        chk_resp("idle", 0, 0);

        // Lone fetch: grant now, data one cycle later.
        next_cycle();
        drive(1, 32'h1C00_0000, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_grant("fetch", 1, 0);
        chk("fetch_sram_addr", sram_addr, 32'h1C00_0000);
        chk("fetch_sram_we", 32'(sram_we), 32'h0);
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_grant("fetch_rsp", 0, 0);
        chk_resp("fetch_rsp", 1, 0);
        chk("fetch_rdata", inst_rdata, 32'h0280_0400);

        // Simultaneous requests: data first, inst as soon as data drops.
        next_cycle();
        drive(1, 32'h1C00_0004, 1, 0, 4'h0, 32'h2000, 32'h0);
        chk_grant("both", 0, 1);
        chk("both_sram_addr", sram_addr, 32'h0000_2000);
        next_cycle();
        drive(1, 32'h1C00_0004, 0, 0, 4'h0, 32'h2000, 32'h0);
        chk_grant("both_i", 1, 0);
        chk_resp("both_i", 0, 1);
        chk("both_drdata", data_rdata, 32'h1111_2222);
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("both_irsp", 1, 0);
        chk("both_irdata", inst_rdata, 32'h3333_4444);

        // Both held: three data wins, then inst, and the counter restarts.
        pat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(1, 32'h1C00_0000, 1, 0, 4'h0, 32'h2000, 32'h0);
            chk_grant($sformatf("starve%0d", k), !pat[k], pat[k]);
            if (k > 0) chk_resp($sformatf("starve%0d", k), !pat[k-1], pat[k-1]);
        end
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("starve_end", 1, 0);

        // A cycle without inst_req clears the starvation count.
        ir_pat = 7'b1111011;
        gd_pat = 7'b0111111;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            drive(ir_pat[k], 32'h1C00_0000, 1, 0, 4'h0, 32'h2000, 32'h0);
            chk_grant($sformatf("clr%0d", k), !gd_pat[k], gd_pat[k]);
        end
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("clr_end", 1, 0);

        // Partial store, then read the word back.
        next_cycle();
        drive(0, 32'h0, 1, 1, 4'b0100, 32'h1000, 32'h00AB_0000);
        chk_grant("store", 0, 1);
        chk("store_sram_we", 32'(sram_we), 32'h4);
        chk("store_sram_addr", sram_addr, 32'h0000_1000);
        chk("store_sram_wdata", sram_wdata, 32'h00AB_0000);
        next_cycle();
        drive(0, 32'h0, 1, 0, 4'b1111, 32'h1000, 32'h0);
        chk_resp("store_rsp", 0, 1);
        chk_grant("load", 0, 1);
        chk("load_sram_we", 32'(sram_we), 32'h0);
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("load_rsp", 0, 1);
        chk("load_rdata", data_rdata, 32'h11AB_3344);

        // Alternating single requesters, one access per cycle.
        next_cycle();
        drive(0, 32'h0, 1, 0, 4'h0, 32'h2000, 32'h0);
        chk_grant("alt0", 0, 1);
        next_cycle();
        drive(1, 32'h1C00_0004, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_grant("alt1", 1, 0);
        chk_resp("alt1", 0, 1);
        chk("alt1_rdata", data_rdata, 32'h1111_2222);
        next_cycle();
        drive(0, 32'h0, 1, 0, 4'h0, 32'h1000, 32'h0);
        chk_grant("alt2", 0, 1);
        chk_resp("alt2", 1, 0);
        chk("alt2_rdata", inst_rdata, 32'h3333_4444);
        next_cycle();
        drive(1, 32'h1C00_0000, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_grant("alt3", 1, 0);
        chk_resp("alt3", 0, 1);
        chk("alt3_rdata", data_rdata, 32'h11AB_3344);
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("alt4", 1, 0);
        chk("alt4_rdata", inst_rdata, 32'h0280_0400);

        // Reset right after a grant drops the pending response.
        next_cycle();
        drive(0, 32'h0, 1, 0, 4'h0, 32'h2000, 32'h0);
        chk_grant("rstmid_g", 0, 1);
        next_cycle();
        reset = 1'b1;
        drive(1, 32'h1C00_0000, 1, 1, 4'hF, 32'h2000, 32'h0);
        chk_grant("rstmid", 0, 0);
        chk("rstmid_sram_we", 32'(sram_we), 32'h0);
        chk_resp("rstmid", 0, 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("rstmid_after", 0, 0);
        chk_grant("rstmid_after", 0, 0);

        // Normal operation resumes.
        next_cycle();
        drive(1, 32'h1C00_0004, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_grant("resume", 1, 0);
        next_cycle();
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk_resp("resume_rsp", 1, 0);
        chk("resume_rdata", inst_rdata, 32'h3333_4444);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
